u_mcb_rd_chk: RTL and testbench

//  Read-side companion of the MCB user write-port driver. On each start pulse (typically the write

---
 rtl/u_mcb_rd_chk.sv | 172 +++++++++++++++++
 tb/tb_u_mcb_rd_chk.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_mcb_rd_chk.sv
// -----------------------------------------------------------------------------
// u_mcb_rd_chk
// Read-side checker for the MCB user port. Each start pulse issues one read
// command for the next block, drains the read-data FIFO and compares every
// 128-bit word against an alternating PATTERN / ~PATTERN sequence. Reports a
// per-burst done pulse, sticky mismatch and watchdog flags, and a saturating
// mismatch counter for on-board test.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   u_rd_start      pulse: read and check the next block (one-deep pending)
//   err_clr         pulse: clear err_cnt, rd_err, rd_timeout
//   u_rd_cmd_full   MCB command FIFO full
//   u_rd_empty      MCB read-data FIFO empty (first-word-fall-through)
//   u_rd_data       MCB read data, valid while u_rd_empty is low
//   u_rd_cmd_en     one-cycle read command strobe
//   u_rd_addr       read byte address, stable from CMD until DONE
//   u_rd_len        read burst length (BURST_LEN)
//   u_rd_en         read-data FIFO pop (combinational)
//   rd_busy         high in any state except IDLE
//   rd_done         one-cycle pulse at burst end
//   rd_err          sticky: at least one word mismatched
//   rd_timeout      sticky: a burst was aborted by the watchdog
//   err_cnt         count of mismatching words, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module u_mcb_rd_chk #(
  parameter int unsigned  BURST_LEN   = 64,
  parameter logic [29:0]  ADDR_INC    = 30'h400,
  parameter logic [29:0]  END_ADDR    = 30'h0FFF_FC00,
  parameter logic [127:0] PATTERN     = {16{8'hAA}},
  parameter int unsigned  TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         u_rd_start,
  input  logic         err_clr,
  input  logic         u_rd_cmd_full,
  input  logic         u_rd_empty,
  input  logic [127:0] u_rd_data,
  output logic         u_rd_cmd_en,
  output logic [29:0]  u_rd_addr,
  output logic [6:0]   u_rd_len,
  output logic         u_rd_en,
  output logic         rd_busy,
  output logic         rd_done,
  output logic         rd_err,
  output logic         rd_timeout,
  output logic [15:0]  err_cnt
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic              pending;
  logic [29:0]       addr_next;
  logic [BEAT_W-1:0] beat;
  logic [WD_W-1:0]   wd_cnt;

  logic              beat_last;
  logic              wd_expired;
  logic              timeout_hit;
  logic              mismatch;
  logic [127:0]      exp_word;

  // The burst length is a build-time constant; it never changes at run time.
  assign u_rd_len = 7'(BURST_LEN);

  // Pop whenever data is available in DATA. The FSM leaves DATA on the edge
  // that consumes the last beat, so no extra word is ever popped.
  assign u_rd_en     = (state == DATA) && !u_rd_empty;
  assign beat_last   = (beat == BEAT_W'(BURST_LEN - 1));
  assign wd_expired  = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign timeout_hit = (state == DATA) && !u_rd_en && wd_expired;

  // Even beats carry PATTERN, odd beats its complement.
  assign exp_word = beat[0] ? ~PATTERN : PATTERN;
  assign mismatch = u_rd_en && (u_rd_data != exp_word);

  // Control FSM with registered strobes.
  // NOTE: every register here uses non-blocking assignment so all state moves
  // together on the clock edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= 1'b0;
      addr_next   <= '0;
      u_rd_addr   <= '0;
      u_rd_cmd_en <= 1'b0;
      rd_busy     <= 1'b0;
      rd_done     <= 1'b0;
      beat        <= '0;
      wd_cnt      <= '0;
    end else begin
      u_rd_cmd_en <= 1'b0;
      rd_done     <= 1'b0;

      // One-deep request memory: a start outside IDLE is remembered once,
      // further starts while it is set collapse into it.
      if (u_rd_start && (state != IDLE)) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (u_rd_start || pending) begin
            pending   <= 1'b0;
            u_rd_addr <= addr_next;
            rd_busy   <= 1'b1;
            state     <= CMD;
          end
        end
        CMD: begin
          if (!u_rd_cmd_full) begin
            u_rd_cmd_en <= 1'b1;
            beat        <= '0;
            wd_cnt      <= '0;
            state       <= DATA;
          end
        end
        DATA: begin
          if (u_rd_en) begin
            wd_cnt <= '0;
            beat   <= beat + 1'b1;
            if (beat_last) begin
              rd_done <= 1'b1;
              state   <= DONE;
            end
          end else if (wd_expired) begin
            // Watchdog abort; the sticky flag is set in the status block.
            rd_done <= 1'b1;
            state   <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE: begin
          addr_next <= (addr_next == END_ADDR) ? '0 : addr_next + ADDR_INC;
          rd_busy   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky status and saturating error counter; err_clr wins over any update
  // in the same cycle and leaves the FSM and address untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_err     <= 1'b0;
      rd_timeout <= 1'b0;
      err_cnt    <= '0;
    end else if (err_clr) begin
      rd_err     <= 1'b0;
      rd_timeout <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (mismatch) begin
        rd_err <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (timeout_hit) rd_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_u_mcb_rd_chk.sv
// -----------------------------------------------------------------------------
// tb_u_mcb_rd_chk
// Scoreboard bench for u_mcb_rd_chk. The stimulus pushes expected command
// addresses and expected burst results into queues; a monitor on the falling
// edge pops and compares whenever the DUT strobes u_rd_cmd_en or rd_done.
// A second instance with a large address step exercises the END_ADDR wrap.
// -----------------------------------------------------------------------------
module tb_u_mcb_rd_chk;

  localparam logic [127:0] PAT = {16{8'hAA}};

  typedef struct {
    int pops;
    int errs;
    bit err;
    bit tmo;
  } done_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         u_rd_start;
  logic         err_clr;
  logic         u_rd_cmd_full;
  logic         u_rd_empty;
  logic [127:0] u_rd_data;
  logic         u_rd_cmd_en;
  logic [29:0]  u_rd_addr;
  logic [6:0]   u_rd_len;
  logic         u_rd_en;
  logic         rd_busy;
  logic         rd_done;
  logic         rd_err;
  logic         rd_timeout;
  logic [15:0]  err_cnt;

  // Wrap-test instance signals
  logic         w_start;
  logic         w_clr;
  logic         w_full;
  logic         w_empty;
  logic [127:0] w_data;
  logic         w_cmd_en;
  logic [29:0]  w_addr;
  logic [6:0]   w_len;
  logic         w_rd_en;
  logic         w_busy;
  logic         w_done;
  logic         w_err;
  logic         w_tmo;
  logic [15:0]  w_err_cnt;
  logic         w_tog;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Scoreboard queues
  logic [29:0] exp_cmd_q[$];
  done_t       exp_done_q[$];
  logic [29:0] exp_w_q[$];

  // Monitor-owned observations
  int cmd_cnt = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int last_cmd_cyc = 0;
  int last_pop_cyc = 0;
  int last_done_cyc = 0;
  int w_done_cnt = 0;

  // Read-data FIFO model (first-word-fall-through)
  logic [127:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int start_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign u_rd_empty = (rd_ptr == wr_ptr);
  assign u_rd_data  = mem[rd_ptr[9:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_ptr <= wr_ptr;
    else if (u_rd_en) rd_ptr <= rd_ptr + 1;
  end

  // Wrap instance always has a good word ready.
  assign w_empty = 1'b0;
  assign w_data  = w_tog ? ~PAT : PAT;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       w_tog <= 1'b0;
    else if (w_rd_en) w_tog <= ~w_tog;
  end

  u_mcb_rd_chk dut (
    .clk(clk), .rst_n(rst_n), .u_rd_start(u_rd_start), .err_clr(err_clr),
    .u_rd_cmd_full(u_rd_cmd_full), .u_rd_empty(u_rd_empty), .u_rd_data(u_rd_data),
    .u_rd_cmd_en(u_rd_cmd_en), .u_rd_addr(u_rd_addr), .u_rd_len(u_rd_len),
    .u_rd_en(u_rd_en), .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err),
    .rd_timeout(rd_timeout), .err_cnt(err_cnt)
  );

  u_mcb_rd_chk #(.ADDR_INC(30'h0FFF_FC00)) dut_w (
    .clk(clk), .rst_n(rst_n), .u_rd_start(w_start), .err_clr(w_clr),
    .u_rd_cmd_full(w_full), .u_rd_empty(w_empty), .u_rd_data(w_data),
    .u_rd_cmd_en(w_cmd_en), .u_rd_addr(w_addr), .u_rd_len(w_len),
    .u_rd_en(w_rd_en), .rd_busy(w_busy), .rd_done(w_done), .rd_err(w_err),
    .rd_timeout(w_tmo), .err_cnt(w_err_cnt)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every DUT strobe.
  always @(negedge clk) begin
    if (!rst_n) begin
      pop_cnt = 0;
    end else begin
      if (u_rd_en) begin
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (u_rd_cmd_en) begin
        cmd_cnt++;
        last_cmd_cyc = cyc;
        if (exp_cmd_q.size() == 0) begin
          check("unexpected_cmd", 1, 0);
        end else begin
          check("cmd_addr", u_rd_addr, exp_cmd_q.pop_front());
          check("cmd_len", u_rd_len, 64);
        end
      end
      if (rd_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          done_t e;
          e = exp_done_q.pop_front();
          check("done_pops", pop_cnt, e.pops);
          check("done_err_cnt", err_cnt, e.errs);
          check("done_rd_err", rd_err, e.err);
          check("done_rd_timeout", rd_timeout, e.tmo);
        end
        pop_cnt = 0;
      end
      if (w_cmd_en) begin
        if (exp_w_q.size() == 0) check("w_unexpected_cmd", 1, 0);
        else                     check("w_cmd_addr", w_addr, exp_w_q.pop_front());
      end
      if (w_done) w_done_cnt++;
    end
  end

  task automatic push_burst(input int n, input int bad0, input int bad1);
    for (int i = 0; i < n; i++) begin
      if (i == bad0 || i == bad1) mem[wr_ptr[9:0]] = '0;
      else                        mem[wr_ptr[9:0]] = i[0] ? ~PAT : PAT;
      wr_ptr++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    u_rd_start = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    u_rd_start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic expect_burst(input logic [29:0] addr, input int pops, input int errs,
                              input bit err, input bit tmo);
    done_t d;
    d.pops = pops; d.errs = errs; d.err = err; d.tmo = tmo;
    exp_cmd_q.push_back(addr);
    exp_done_q.push_back(d);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) check({name, "_timeout"}, done_cnt, target);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; u_rd_start = 1'b0; err_clr = 1'b0; u_rd_cmd_full = 1'b0;
    w_start = 1'b0; w_clr = 1'b0; w_full = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmd_en", u_rd_cmd_en, 0);
    check("rst_addr", u_rd_addr, 0);
    check("rst_len", u_rd_len, 64);
    check("rst_busy", rd_busy, 0);
    check("rst_done", rd_done, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: clean burst, latency start -> cmd_en of two cycles
    push_burst(64, -1, -1);
    expect_burst(30'h0, 64, 0, 0, 0);
    pulse_start();
    wait_done(1, 200, "t1");
    check("t1_latency", last_cmd_cyc - start_cyc, 2);
    @(negedge clk);
    check("t1_busy_after", rd_busy, 0);

    // 2: two bad words, then clear
    push_burst(64, 5, 9);
    expect_burst(30'h400, 64, 2, 1, 0);
    pulse_start();
    wait_done(2, 200, "t2");
    pulse_clr();
    check("t2_clr_err_cnt", err_cnt, 0);
    check("t2_clr_rd_err", rd_err, 0);

    // 3: command FIFO full for 10 cycles
    push_burst(64, -1, -1);
    expect_burst(30'h800, 64, 0, 0, 0);
    c0 = cmd_cnt;
    u_rd_cmd_full = 1'b1;
    pulse_start();
    repeat (10) @(negedge clk);
    check("t3_no_cmd_while_full", cmd_cnt, c0);
    check("t3_busy_while_full", rd_busy, 1);
    u_rd_cmd_full = 1'b0;
    wait_done(3, 200, "t3");
    check("t3_one_strobe", cmd_cnt, c0 + 1);

    // 4: FIFO stalls after 20 words -> watchdog abort after 1024 idle cycles
    push_burst(20, -1, -1);
    expect_burst(30'hC00, 20, 0, 0, 1);
    pulse_start();
    wait_done(4, 1300, "t4");
    check("t4_idle_span", last_done_cyc - last_pop_cyc, 1025);
    pulse_clr();
    check("t4_clr_timeout", rd_timeout, 0);

    // 5: END_ADDR wrap on the second instance (0 -> END_ADDR -> 0)
    exp_w_q.push_back(30'h0);
    exp_w_q.push_back(30'h0FFF_FC00);
    exp_w_q.push_back(30'h0);
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      @(negedge clk); w_start = 1'b1;
      @(negedge clk); w_start = 1'b0;
      while (w_done_cnt < k + 1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (w_done_cnt < k + 1) check("t5_done_timeout", w_done_cnt, k + 1);
    end
    check("t5_w_err_cnt", w_err_cnt, 0);
    check("t5_w_cmd_left", exp_w_q.size(), 0);

    // 6a: two starts during DATA -> exactly one extra burst
    expect_burst(30'h1000, 64, 0, 0, 0);
    expect_burst(30'h1400, 64, 0, 0, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    pulse_start();
    c0 = cmd_cnt;
    push_burst(64, -1, -1);
    push_burst(64, -1, -1);
    wait_done(6, 400, "t6");
    repeat (20) @(negedge clk);
    check("t6_one_extra_cmd", cmd_cnt, c0 + 1);
    check("t6_idle_busy", rd_busy, 0);

    // 6b: asynchronous reset mid-DATA
    exp_cmd_q.push_back(30'h1800);
    push_burst(10, 3, -1);
    pulse_start();
    repeat (14) @(negedge clk);
    check("t6_pre_rst_err_cnt", err_cnt, 1);
    check("t6_pre_rst_busy", rd_busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_addr", u_rd_addr, 0);
    check("t6_rst_len", u_rd_len, 64);
    check("t6_rst_rd_en", u_rd_en, 0);
    check("t6_rst_busy", rd_busy, 0);
    check("t6_rst_err", rd_err, 0);
    check("t6_rst_err_cnt", err_cnt, 0);
    check("t6_rst_cmd_en", u_rd_cmd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset the address sequence restarts at 0
    push_burst(64, -1, -1);
    expect_burst(30'h0, 64, 0, 0, 0);
    pulse_start();
    wait_done(7, 200, "t6_post");
    repeat (4) @(negedge clk);
    check("sb_cmd_left", exp_cmd_q.size(), 0);
    check("sb_done_left", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
